reservation_station: RTL and testbench
======================================

# reservation_station

Issue-side counterpart to the execute stage's functional units. It buffers dispatched micro-ops and tracks source-operand readiness by snooping the three CDB buses (`cdb_add`, `cdb_mul`, `cdb_div`). It selects the oldest fully-ready entry and drives a one-cycle `start` pulse with its tags (`rob_idx`, `pd_s`, `rd_s`) and physical source indices to one FU and the physical register file. One instance sits in front of each FU class.

## Interface
- `DEPTH`, 8, number of entries (power of two, 2..16)
- `PHYS_REG_BITS`, 6, physical register index width
- `ROB_IDX_BITS`, 6, ROB index width
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset; one clock; reset is asynchronous and active-low (asserted when 0)
- `flush`  in  1  synchronous: invalidate all entries
- `dispatch_valid`  in  1  dispatch request
- `dispatch_ready`  out  1  at least one free entry
- `dispatch_info`  in  decode_info_t  decoded op
- `dispatch_ps1`, `dispatch_ps2`  in  PHYS_REG_BITS  source physical regs
- `dispatch_ps1_rdy`, `dispatch_ps2_rdy`  in  1  source already available
- `dispatch_pd`  in  PHYS_REG_BITS  destination physical reg
- `dispatch_rd`  in  5  destination architectural reg
- `dispatch_rob_idx`  in  ROB_IDX_BITS  ROB slot
- `cdb_add`, `cdb_mul`, `cdb_div`  in  cdb_t  result broadcasts (valid, rob_idx, pd_s, rd_s, rd_v)
- `fu_ready`  in  1  target FU can accept an op this cycle
- `start`  out  1  one-cycle issue pulse to FU
- `issue_info`  out  decode_info_t  op for FU
- `issue_ps1`, `issue_ps2`  out  PHYS_REG_BITS  regfile read indices
- `issue_pd`  out  PHYS_REG_BITS; `issue_rd`  out  5; `issue_rob_idx`  out  ROB_IDX_BITS  tags for FU
- `occupancy`  out  $clog2(DEPTH)+1  valid entry count

## Operation
- Entry state: valid, info, ps1/ps2, rdy1/rdy2, pd, rd, rob_idx. Age is kept in a DEPTH×DEPTH age matrix. `age[i][j]=1` means entry i is older than entry j.
- Dispatch accepted when `dispatch_valid && dispatch_ready`. The lowest-index free entry is written.
  - The new entry's age row is set to 0.
  - Its column is set to 1 in every currently valid entry.
- Wakeup: for each CDB bus with `valid=1` and `rd_s!=0`, every valid entry whose ps1 (ps2) equals `pd_s` sets rdy1 (rdy2).
  - A bus with `rd_s==0` never wakes anything.
- Dispatch bypass: if `dispatch_ps1`/`ps2` matches a qualifying broadcast in the dispatch cycle, the written rdy bit is 1 even when `dispatch_psX_rdy=0`.
- Select (combinational): candidates are valid entries with rdy1 && rdy2. The winner is the candidate with no older candidate.
  - If `fu_ready` and a winner exists, the winner's fields are registered onto the issue outputs and the winner's valid bit clears.
- `dispatch_ready = (occupancy != DEPTH)`. This is computed from registered state only; a slot freed by issue in the same cycle is not reusable until next cycle.
- `occupancy` next = occupancy + accepted dispatch − issue; both may occur in one cycle.
- `flush`: all valid bits clear, occupancy→0, `start`→0 next cycle. Dispatch, issue and wakeup in the same cycle are discarded.

## Timing
- Reset values: `start=0`, `occupancy=0`, `dispatch_ready=1`, all issue_* outputs 0, all entries invalid, age matrix 0.
- Dispatch in cycle t → entry visible to select in t+1 (earliest `start` in t+2).
- Broadcast in cycle t → woken entry eligible in t+1 (`start` earliest t+2).
- Select in cycle t (`fu_ready=1` sampled in t) → `start=1` and issue_* valid in t+1 for exactly one cycle, unless another issue follows back-to-back.
- Issue outputs hold their last values when `start=0`.
- `fu_ready=0` blocks issue; ready entries stay buffered with age preserved.
- At most one dispatch and one issue per cycle.
- Reset asserted mid-operation clears all state immediately, independent of `clk`.

## Test plan
- Reset then single dispatch (ps1=5 rdy, ps2=6 rdy, pd=9, rob_idx=3), `fu_ready=1` → `start` one cycle, two cycles after dispatch, with issue_pd=9, issue_rob_idx=3; occupancy returns to 0.
- Dispatch A (ps1=7 not ready), then B (both ready); broadcast `cdb_mul` pd_s=7 rd_s=4 → B issues first. A issues on the cycle after B's start, provided `fu_ready=1`.
- Dispatch with ps2=12 not ready in the same cycle `cdb_add` broadcasts pd_s=12 rd_s=1 → entry issues two cycles later. A broadcast with rd_s=0, pd_s=12 must not wake it.
- Fill all 8 entries with `fu_ready=0` → `dispatch_ready=0`, a 9th `dispatch_valid` is ignored, occupancy=8.
  - Then `fu_ready=1` → entries issue in dispatch order, one per cycle.
- With 4 valid entries, assert `flush` together with a dispatch → next cycle occupancy=0, `start=0`, and nothing issues afterward.
- Drop `rst` to 0 mid-cycle while entries are valid and `start=1` → `start`, occupancy and all issue_* read 0 before the next clock edge.

Source files
------------

// File: rtl/reservation_station_if.sv
// Shared types plus the dispatch / broadcast / issue bundle of a reservation station.
// Latency: none; this file only declares types and wires.
// Backpressure: dispatch_ready gates dispatch, fu_ready gates issue.

localparam int RS_PREG_W = 6;
localparam int RS_ROB_W  = 6;

typedef struct packed {
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] imm;
} decode_info_t;

typedef struct packed {
  logic                 valid;
  logic [RS_ROB_W-1:0]  rob_idx;
  logic [RS_PREG_W-1:0] pd_s;
  logic [4:0]           rd_s;
  logic [31:0]          rd_v;
} cdb_t;

interface reservation_station_if #(
  parameter int DEPTH         = 8,
  parameter int PHYS_REG_BITS = RS_PREG_W,
  parameter int ROB_IDX_BITS  = RS_ROB_W
);
  logic                     flush;
  logic                     dispatch_valid;
  logic                     dispatch_ready;
  decode_info_t             dispatch_info;
  logic [PHYS_REG_BITS-1:0] dispatch_ps1;
  logic [PHYS_REG_BITS-1:0] dispatch_ps2;
  logic                     dispatch_ps1_rdy;
  logic                     dispatch_ps2_rdy;
  logic [PHYS_REG_BITS-1:0] dispatch_pd;
  logic [4:0]               dispatch_rd;
  logic [ROB_IDX_BITS-1:0]  dispatch_rob_idx;
  cdb_t                     cdb_add;
  cdb_t                     cdb_mul;
  cdb_t                     cdb_div;
  logic                     fu_ready;
  logic                     start;
  decode_info_t             issue_info;
  logic [PHYS_REG_BITS-1:0] issue_ps1;
  logic [PHYS_REG_BITS-1:0] issue_ps2;
  logic [PHYS_REG_BITS-1:0] issue_pd;
  logic [4:0]               issue_rd;
  logic [ROB_IDX_BITS-1:0]  issue_rob_idx;
  logic [$clog2(DEPTH):0]   occupancy;

  // Producer side: dispatch stage, CDBs and the FU handshake.
  modport master (
    output flush, dispatch_valid, dispatch_info, dispatch_ps1, dispatch_ps2,
           dispatch_ps1_rdy, dispatch_ps2_rdy, dispatch_pd, dispatch_rd,
           dispatch_rob_idx, cdb_add, cdb_mul, cdb_div, fu_ready,
    input  dispatch_ready, start, issue_info, issue_ps1, issue_ps2, issue_pd,
           issue_rd, issue_rob_idx, occupancy
  );

  // Reservation station side.
  modport slave (
    input  flush, dispatch_valid, dispatch_info, dispatch_ps1, dispatch_ps2,
           dispatch_ps1_rdy, dispatch_ps2_rdy, dispatch_pd, dispatch_rd,
           dispatch_rob_idx, cdb_add, cdb_mul, cdb_div, fu_ready,
    output dispatch_ready, start, issue_info, issue_ps1, issue_ps2, issue_pd,
           issue_rd, issue_rob_idx, occupancy
  );
endinterface

// File: rtl/reservation_station.sv
// Buffers dispatched micro-ops, wakes sources from the CDBs, issues the oldest ready op.
// Latency: dispatch or wakeup in t gives start at t+2 at the earliest; start is registered.
// Backpressure: dispatch_ready drops when full; fu_ready=0 holds ready entries in place.

module reservation_station #(
  parameter int DEPTH         = 8,
  parameter int PHYS_REG_BITS = RS_PREG_W,
  parameter int ROB_IDX_BITS  = RS_ROB_W
) (
  input logic                  clk,
  input logic                  rst,
  reservation_station_if.slave io
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = IDX_W + 1;

  // Entry state. age_q[i][j]=1 means entry i was dispatched before entry j.
  logic [DEPTH-1:0]         valid_q, rdy1_q, rdy2_q;
  logic [DEPTH-1:0]         age_q [DEPTH];
  decode_info_t             info_q [DEPTH];
  logic [PHYS_REG_BITS-1:0] ps1_q [DEPTH];
  logic [PHYS_REG_BITS-1:0] ps2_q [DEPTH];
  logic [PHYS_REG_BITS-1:0] pd_q [DEPTH];
  logic [4:0]               rd_q [DEPTH];
  logic [ROB_IDX_BITS-1:0]  rob_q [DEPTH];
  logic [OCC_W-1:0]         occ_q;

  // Registered issue port; holds its last value while start is low.
  logic                     start_q;
  decode_info_t             iss_info_q;
  logic [PHYS_REG_BITS-1:0] iss_ps1_q, iss_ps2_q, iss_pd_q;
  logic [4:0]               iss_rd_q;
  logic [ROB_IDX_BITS-1:0]  iss_rob_q;

  logic [DEPTH-1:0] wake1, wake2, cand, blocked, win_vec;
  logic             disp_wake1, disp_wake2;
  logic [IDX_W-1:0] alloc_idx, win_idx;
  logic             win_vld, disp_ready, disp_acc, issue_fire;

  // A broadcast only wakes a tag when it carries a real architectural destination.
  function automatic logic bus_hit(input cdb_t b, input logic [PHYS_REG_BITS-1:0] p);
    return b.valid && (b.rd_s != 5'd0) && (b.pd_s == p);
  endfunction

  // Tag match of every CDB against stored sources and against the incoming dispatch.
  always_comb begin
    wake1 = '0;
    wake2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wake1[i] = bus_hit(io.cdb_add, ps1_q[i]) | bus_hit(io.cdb_mul, ps1_q[i]) |
                 bus_hit(io.cdb_div, ps1_q[i]);
      wake2[i] = bus_hit(io.cdb_add, ps2_q[i]) | bus_hit(io.cdb_mul, ps2_q[i]) |
                 bus_hit(io.cdb_div, ps2_q[i]);
    end
    disp_wake1 = bus_hit(io.cdb_add, io.dispatch_ps1) | bus_hit(io.cdb_mul, io.dispatch_ps1) |
                 bus_hit(io.cdb_div, io.dispatch_ps1);
    disp_wake2 = bus_hit(io.cdb_add, io.dispatch_ps2) | bus_hit(io.cdb_mul, io.dispatch_ps2) |
                 bus_hit(io.cdb_div, io.dispatch_ps2);
  end

  // Lowest-index free slot receives the next dispatch.
  always_comb begin
    alloc_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) alloc_idx = IDX_W'(i);
    end
  end

  // Oldest-ready select: a candidate wins when no other candidate is older than it.
  always_comb begin
    cand    = valid_q & rdy1_q & rdy2_q;
    blocked = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (cand[j] && age_q[j][i]) blocked[i] = 1'b1;
      end
    end
    win_vec = cand & ~blocked;
    win_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (win_vec[i]) win_idx = IDX_W'(i);
    end
    win_vld = |cand;
  end

  // Ready is purely registered, so a slot freed by this cycle's issue waits a cycle.
  assign disp_ready = (occ_q != OCC_W'(DEPTH));
  assign disp_acc   = io.dispatch_valid && disp_ready;
  assign issue_fire = io.fu_ready && win_vld;

  // Control state: valid/ready bits, age matrix, occupancy and the issue register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q    <= '0;
      rdy1_q     <= '0;
      rdy2_q     <= '0;
      occ_q      <= '0;
      start_q    <= 1'b0;
      iss_info_q <= '0;
      iss_ps1_q  <= '0;
      iss_ps2_q  <= '0;
      iss_pd_q   <= '0;
      iss_rd_q   <= '0;
      iss_rob_q  <= '0;
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else if (io.flush) begin
      valid_q <= '0;
      occ_q   <= '0;
      start_q <= 1'b0;
    end else begin
      start_q <= issue_fire;
      if (issue_fire) begin
        iss_info_q       <= info_q[win_idx];
        iss_ps1_q        <= ps1_q[win_idx];
        iss_ps2_q        <= ps2_q[win_idx];
        iss_pd_q         <= pd_q[win_idx];
        iss_rd_q         <= rd_q[win_idx];
        iss_rob_q        <= rob_q[win_idx];
        valid_q[win_idx] <= 1'b0;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i]) begin
          if (wake1[i]) rdy1_q[i] <= 1'b1;
          if (wake2[i]) rdy2_q[i] <= 1'b1;
        end
      end
      if (disp_acc) begin
        valid_q[alloc_idx] <= 1'b1;
        rdy1_q[alloc_idx]  <= io.dispatch_ps1_rdy | disp_wake1;
        rdy2_q[alloc_idx]  <= io.dispatch_ps2_rdy | disp_wake2;
        for (int j = 0; j < DEPTH; j++) age_q[j][alloc_idx] <= valid_q[j];
        age_q[alloc_idx] <= '0;
      end
      occ_q <= occ_q + OCC_W'(disp_acc) - OCC_W'(issue_fire);
    end
  end

  // Payload of an accepted dispatch; no reset needed since valid_q qualifies it.
  always_ff @(posedge clk) begin
    if (disp_acc && !io.flush) begin
      info_q[alloc_idx] <= io.dispatch_info;
      ps1_q[alloc_idx]  <= io.dispatch_ps1;
      ps2_q[alloc_idx]  <= io.dispatch_ps2;
      pd_q[alloc_idx]   <= io.dispatch_pd;
      rd_q[alloc_idx]   <= io.dispatch_rd;
      rob_q[alloc_idx]  <= io.dispatch_rob_idx;
    end
  end

  // Broadcast ROB index and value are not needed for wakeup.
  logic unused_cdb_fields;
  assign unused_cdb_fields = ^{io.cdb_add.rob_idx, io.cdb_add.rd_v, io.cdb_mul.rob_idx,
                               io.cdb_mul.rd_v, io.cdb_div.rob_idx, io.cdb_div.rd_v};

  assign io.dispatch_ready = disp_ready;
  assign io.occupancy      = occ_q;
  assign io.start          = start_q;
  assign io.issue_info     = iss_info_q;
  assign io.issue_ps1      = iss_ps1_q;
  assign io.issue_ps2      = iss_ps2_q;
  assign io.issue_pd       = iss_pd_q;
  assign io.issue_rd       = iss_rd_q;
  assign io.issue_rob_idx  = iss_rob_q;
endmodule

// File: tb/tb_reservation_station.sv
// Directed checks of the reservation station: per-cycle vector table plus reset sequences.
// Latency: outputs are sampled 1 ns after each rising edge.
// Backpressure: fu_ready and dispatch_valid are driven straight from the vectors.

module tb_reservation_station;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reservation_station_if #(.DEPTH(8), .PHYS_REG_BITS(6), .ROB_IDX_BITS(6)) rs_if ();

  reservation_station #(.DEPTH(8), .PHYS_REG_BITS(6), .ROB_IDX_BITS(6)) dut (
    .clk (clk),
    .rst (rst),
    .io  (rs_if)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // One cycle of stimulus and the outputs expected just after that cycle's edge.
  typedef struct {
    logic       fl, dv;
    logic [5:0] ps1;
    logic       r1;
    logic [5:0] ps2;
    logic       r2;
    logic [5:0] pd, rob;
    logic [1:0] bus;      // 0 none, 1 add, 2 mul, 3 div
    logic [5:0] bpd;
    logic [4:0] brd;
    logic       fu;
    logic       es;
    logic [3:0] eo;
    logic       ed;
    logic       chk;      // also compare issue payload
    logic [5:0] eps1, epd, erob;
  } vec_t;

  vec_t vq[$];

  function automatic decode_info_t mk_info(input logic [5:0] rob, input logic [5:0] pd);
    decode_info_t d;
    d.opcode = {1'b0, rob};
    d.funct3 = pd[2:0];
    d.imm    = {26'd0, pd};
    return d;
  endfunction

  function automatic vec_t V(input logic fl, input logic dv, input logic [5:0] ps1,
                             input logic r1, input logic [5:0] ps2, input logic r2,
                             input logic [5:0] pd, input logic [5:0] rob, input logic [1:0] bus,
                             input logic [5:0] bpd, input logic [4:0] brd, input logic fu,
                             input logic es, input logic [3:0] eo, input logic ed,
                             input logic chk, input logic [5:0] eps1, input logic [5:0] epd,
                             input logic [5:0] erob);
    vec_t v;
    v.fl = fl;  v.dv = dv;  v.ps1 = ps1; v.r1 = r1; v.ps2 = ps2; v.r2 = r2;
    v.pd = pd;  v.rob = rob; v.bus = bus; v.bpd = bpd; v.brd = brd; v.fu = fu;
    v.es = es;  v.eo = eo;  v.ed = ed;  v.chk = chk;
    v.eps1 = eps1; v.epd = epd; v.erob = erob;
    return v;
  endfunction

  // Idle cycle, optionally with one broadcast.
  function automatic vec_t I(input logic [1:0] bus, input logic [5:0] bpd, input logic [4:0] brd,
                             input logic fu, input logic es, input logic [3:0] eo,
                             input logic ed, input logic chk, input logic [5:0] eps1,
                             input logic [5:0] epd, input logic [5:0] erob);
    return V(0, 0, 0, 0, 0, 0, 0, 0, bus, bpd, brd, fu, es, eo, ed, chk, eps1, epd, erob);
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    rs_if.flush = 0; rs_if.dispatch_valid = 0; rs_if.dispatch_info = '0;
    rs_if.dispatch_ps1 = 0; rs_if.dispatch_ps2 = 0; rs_if.dispatch_ps1_rdy = 0;
    rs_if.dispatch_ps2_rdy = 0; rs_if.dispatch_pd = 0; rs_if.dispatch_rd = 0;
    rs_if.dispatch_rob_idx = 0; rs_if.cdb_add = '0; rs_if.cdb_mul = '0; rs_if.cdb_div = '0;
    rs_if.fu_ready = 0;
  endtask

  task automatic apply(input vec_t x, input int k);
    cdb_t b;
    b = '0;
    b.valid = 1'b1;
    b.pd_s  = x.bpd;
    b.rd_s  = x.brd;
    b.rd_v  = 32'hdead_0000 | 32'(k);
    rs_if.flush            = x.fl;
    rs_if.dispatch_valid   = x.dv;
    rs_if.dispatch_info    = mk_info(x.rob, x.pd);
    rs_if.dispatch_ps1     = x.ps1;
    rs_if.dispatch_ps2     = x.ps2;
    rs_if.dispatch_ps1_rdy = x.r1;
    rs_if.dispatch_ps2_rdy = x.r2;
    rs_if.dispatch_pd      = x.pd;
    rs_if.dispatch_rd      = x.pd[4:0] | 5'd1;
    rs_if.dispatch_rob_idx = x.rob;
    rs_if.cdb_add = '0;
    rs_if.cdb_mul = '0;
    rs_if.cdb_div = '0;
    if (x.bus == 2'd1) rs_if.cdb_add = b;
    if (x.bus == 2'd2) rs_if.cdb_mul = b;
    if (x.bus == 2'd3) rs_if.cdb_div = b;
    rs_if.fu_ready = x.fu;
    @(posedge clk);
    #1;
    check($sformatf("v%0d start", k), 64'(rs_if.start), 64'(x.es));
    check($sformatf("v%0d occupancy", k), 64'(rs_if.occupancy), 64'(x.eo));
    check($sformatf("v%0d dispatch_ready", k), 64'(rs_if.dispatch_ready), 64'(x.ed));
    if (x.chk) begin
      check($sformatf("v%0d issue_ps1", k), 64'(rs_if.issue_ps1), 64'(x.eps1));
      check($sformatf("v%0d issue_pd", k), 64'(rs_if.issue_pd), 64'(x.epd));
      check($sformatf("v%0d issue_rob_idx", k), 64'(rs_if.issue_rob_idx), 64'(x.erob));
      check($sformatf("v%0d issue_info", k), 64'(rs_if.issue_info), 64'(mk_info(x.erob, x.epd)));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " start"}, 64'(rs_if.start), 64'd0);
    check({tag, " occupancy"}, 64'(rs_if.occupancy), 64'd0);
    check({tag, " dispatch_ready"}, 64'(rs_if.dispatch_ready), 64'd1);
    check({tag, " issue_pd"}, 64'(rs_if.issue_pd), 64'd0);
    check({tag, " issue_rob_idx"}, 64'(rs_if.issue_rob_idx), 64'd0);
    check({tag, " issue_ps1"}, 64'(rs_if.issue_ps1), 64'd0);
    check({tag, " issue_ps2"}, 64'(rs_if.issue_ps2), 64'd0);
    check({tag, " issue_rd"}, 64'(rs_if.issue_rd), 64'd0);
    check({tag, " issue_info"}, 64'(rs_if.issue_info), 64'd0);
  endtask

  initial begin
    // Single ready dispatch: start two cycles later, then payload holds.
    vq.push_back(V(0, 1, 5, 1, 6, 1, 9, 3, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0));
    vq.push_back(I(0, 0, 0, 1, 1, 0, 1, 1, 5, 9, 3));
    vq.push_back(I(0, 0, 0, 1, 0, 0, 1, 1, 5, 9, 3));
    // A waits on ps1=7, B ready; mul wakes A while B issues; A issues right after.
    vq.push_back(V(0, 1, 7, 0, 8, 1, 10, 1, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0));
    vq.push_back(V(0, 1, 1, 1, 2, 1, 11, 2, 0, 0, 0, 1, 0, 2, 1, 0, 0, 0, 0));
    vq.push_back(I(2, 7, 4, 1, 1, 1, 1, 1, 1, 11, 2));
    vq.push_back(I(0, 0, 0, 1, 1, 0, 1, 1, 7, 10, 1));
    vq.push_back(I(0, 0, 0, 1, 0, 0, 1, 1, 7, 10, 1));
    // Dispatch-cycle bypass from cdb_add.
    vq.push_back(V(0, 1, 3, 1, 12, 0, 13, 4, 1, 12, 1, 1, 0, 1, 1, 0, 0, 0, 0));
    vq.push_back(I(0, 0, 0, 1, 1, 0, 1, 1, 3, 13, 4));
    // rd_s=0 broadcasts never wake; a real one later does.
    vq.push_back(V(0, 1, 3, 1, 12, 0, 14, 5, 3, 12, 0, 1, 0, 1, 1, 0, 0, 0, 0));
    vq.push_back(I(0, 0, 0, 1, 0, 1, 1, 1, 3, 13, 4));
    vq.push_back(I(1, 12, 0, 1, 0, 1, 1, 0, 0, 0, 0));
    vq.push_back(I(1, 12, 2, 1, 0, 1, 1, 0, 0, 0, 0));
    vq.push_back(I(0, 0, 0, 1, 1, 0, 1, 1, 3, 14, 5));
    // Dispatch and issue in the same cycle, then back-to-back starts.
    vq.push_back(V(0, 1, 4, 1, 4, 1, 15, 6, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0));
    vq.push_back(V(0, 1, 4, 1, 4, 1, 16, 7, 0, 0, 0, 1, 1, 1, 1, 1, 4, 15, 6));
    vq.push_back(I(0, 0, 0, 1, 1, 0, 1, 1, 4, 16, 7));
    // Fill all eight with the FU stalled; a ninth request is refused.
    for (int i = 0; i < 8; i++)
      vq.push_back(V(0, 1, 2, 1, 3, 1, 6'(20 + i), 6'(16 + i), 0, 0, 0, 0,
                     0, 4'(i + 1), (i != 7), 0, 0, 0, 0));
    vq.push_back(V(0, 1, 2, 1, 3, 1, 30, 40, 0, 0, 0, 0, 0, 8, 0, 0, 0, 0, 0));
    // Release the FU: drain in dispatch order, one per cycle.
    for (int i = 0; i < 8; i++)
      vq.push_back(I(0, 0, 0, 1, 1, 4'(7 - i), 1, 1, 2, 6'(20 + i), 6'(16 + i)));
    vq.push_back(I(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0));
    // Four stalled entries, then flush together with a dispatch and a wakeup.
    for (int i = 0; i < 4; i++)
      vq.push_back(V(0, 1, 2, 1, 3, 1, 6'(32 + i), 6'(50 + i), 0, 0, 0, 0,
                     0, 4'(i + 1), 1, 0, 0, 0, 0));
    vq.push_back(V(1, 1, 2, 1, 3, 1, 40, 54, 1, 2, 1, 1, 0, 0, 1, 0, 0, 0, 0));
    vq.push_back(I(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0));
    vq.push_back(I(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0));
    // Two entries so that start is high when reset hits.
    vq.push_back(V(0, 1, 9, 1, 10, 1, 41, 60, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0));
    vq.push_back(V(0, 1, 9, 1, 10, 1, 42, 61, 0, 0, 0, 1, 1, 1, 1, 1, 9, 41, 60));

    // Power-on reset.
    drive_idle();
    rst = 1'b1;
    #2 rst = 1'b0;
    #2 check_all_zero("reset");
    #8 rst = 1'b1;

    foreach (vq[k]) apply(vq[k], k);

    // Asynchronous reset in the middle of a cycle while start=1 and an entry is valid.
    #3 rst = 1'b0;
    #1 check_all_zero("async_reset");
    drive_idle();
    #2 rst = 1'b1;
    apply(I(0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0), 100);
    apply(I(0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0), 101);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
